// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-index width and the per-stage
// destination/write-back slot carried through EXE, MEM and WB.
package pipe_pkg;

    localparam int REG_W = 4;

    typedef struct packed {
        logic [REG_W-1:0] dest;
        logic             wb_en;
        logic             mem_read;
    } slot_t;

    localparam slot_t BUBBLE_SLOT = '0;

endpackage

// File: rtl/stage_slot_reg.sv
// One pipeline slot register. Reset and clear both load a bubble; hold
// (external freeze) takes priority over clear so a frozen stage keeps its
// instruction even if a flush or stall is requested at the same time.
module stage_slot_reg
    import pipe_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  hold,
    input  logic  clear,
    input  slot_t d,
    output slot_t q
);

    // Slot state: reset > hold > clear-to-bubble > load.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= BUBBLE_SLOT;
        end else if (hold) begin
            q <= q;
        end else if (clear) begin
            q <= BUBBLE_SLOT;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Producer side of the operand-forwarding interface. Tracks the EXE, MEM
// and WB slots, raises the ID-stage stall when forwarding cannot cover a
// RAW dependency, and counts stall cycles with a saturating counter.
module hazard_scoreboard #(
    parameter int REG_W = pipe_pkg::REG_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forwarding_en,
    input  logic             freeze,
    input  logic             branch_taken,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_use_src1,
    input  logic             id_use_src2,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_read,
    output logic [REG_W-1:0] exe_dest,
    output logic             exe_wb_en,
    output logic             exe_mem_read,
    output logic [REG_W-1:0] mem_dest,
    output logic             mem_wb_en,
    output logic [REG_W-1:0] wb_dest,
    output logic             wb_wb_en,
    output logic             hazard,
    output logic [CNT_W-1:0] stall_cnt
);

    import pipe_pkg::*;

    slot_t exe_q;
    slot_t mem_q;
    slot_t wb_q;
    slot_t id_slot;
    logic  exe_clear;
    logic  m1, m2, n1, n2;

    assign id_slot   = '{dest: id_dest, wb_en: id_wb_en, mem_read: id_mem_read};
    assign exe_clear = branch_taken | hazard | ~id_valid;

    stage_slot_reg u_exe (
        .clk   (clk),
        .rst   (rst),
        .hold  (freeze),
        .clear (exe_clear),
        .d     (id_slot),
        .q     (exe_q)
    );

    stage_slot_reg u_mem (
        .clk   (clk),
        .rst   (rst),
        .hold  (freeze),
        .clear (1'b0),
        .d     (exe_q),
        .q     (mem_q)
    );

    stage_slot_reg u_wb (
        .clk   (clk),
        .rst   (rst),
        .hold  (freeze),
        .clear (1'b0),
        .d     (mem_q),
        .q     (wb_q)
    );

    assign exe_dest     = exe_q.dest;
    assign exe_wb_en    = exe_q.wb_en;
    assign exe_mem_read = exe_q.mem_read;
    assign mem_dest     = mem_q.dest;
    assign mem_wb_en    = mem_q.wb_en;
    assign wb_dest      = wb_q.dest;
    assign wb_wb_en     = wb_q.wb_en;

    // Source matches against EXE/MEM and the resulting stall decision.
    // WB is excluded: the register file writes before ID reads.
    always_comb begin
        m1     = id_use_src1 & exe_q.wb_en & (id_src1 == exe_q.dest);
        m2     = id_use_src2 & exe_q.wb_en & (id_src2 == exe_q.dest);
        n1     = id_use_src1 & mem_q.wb_en & (id_src1 == mem_q.dest);
        n2     = id_use_src2 & mem_q.wb_en & (id_src2 == mem_q.dest);
        hazard = 1'b0;
        if (id_valid && !branch_taken) begin
            if (forwarding_en) begin
                hazard = exe_q.mem_read & (m1 | m2);
            end else begin
                hazard = m1 | m2 | n1 | n2;
            end
        end
    end

    // Saturating stall-cycle counter; frozen edges are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (hazard && !freeze && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard. A second instance with a 4-bit
// counter exercises saturation within a short run.
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst;
    logic       forwarding_en;
    logic       freeze;
    logic       branch_taken;
    logic       id_valid;
    logic [3:0] id_src1;
    logic [3:0] id_src2;
    logic       id_use_src1;
    logic       id_use_src2;
    logic [3:0] id_dest;
    logic       id_wb_en;
    logic       id_mem_read;

    logic [3:0]  exe_dest, mem_dest, wb_dest;
    logic        exe_wb_en, exe_mem_read, mem_wb_en, wb_wb_en, hazard;
    logic [15:0] stall_cnt;

    logic [3:0] s_exe_dest, s_mem_dest, s_wb_dest;
    logic       s_exe_wb_en, s_exe_mem_read, s_mem_wb_en, s_wb_wb_en, s_hazard;
    logic [3:0] s_stall_cnt;

    hazard_scoreboard #(.REG_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .forwarding_en(forwarding_en), .freeze(freeze),
        .branch_taken(branch_taken), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en),
        .hazard(hazard), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.REG_W(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .forwarding_en(forwarding_en), .freeze(freeze),
        .branch_taken(branch_taken), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .exe_dest(s_exe_dest), .exe_wb_en(s_exe_wb_en), .exe_mem_read(s_exe_mem_read),
        .mem_dest(s_mem_dest), .mem_wb_en(s_mem_wb_en),
        .wb_dest(s_wb_dest), .wb_wb_en(s_wb_wb_en),
        .hazard(s_hazard), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observation: slots, hazard, 16-bit counter, 4-bit counter.
    logic [36:0] obs;
    assign obs = {exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
                  wb_dest, wb_wb_en, hazard, stall_cnt, s_stall_cnt};

    typedef struct packed {
        logic       rst, fwd, frz, br, v;
        logic [3:0] s1;
        logic       u1;
        logic [3:0] s2;
        logic       u2;
        logic [3:0] d;
        logic       wb, mr;
    } stim_t;

    typedef struct {
        string       name;
        logic [36:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic stim_t op(logic v, logic [3:0] s1, logic u1, logic [3:0] s2,
                                 logic u2, logic [3:0] d, logic wb, logic mr);
        stim_t s;
        s = '{rst: 1'b0, fwd: 1'b1, frz: 1'b0, br: 1'b0, v: v, s1: s1, u1: u1,
              s2: s2, u2: u2, d: d, wb: wb, mr: mr};
        return s;
    endfunction

    function automatic stim_t idle();
        return op(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endfunction

    function automatic logic [36:0] mk(logic [3:0] ed, logic ew, logic em,
                                       logic [3:0] md, logic mw,
                                       logic [3:0] wd, logic ww, logic hz, int cnt);
        logic [15:0] c16;
        logic [3:0]  c4;
        c16 = 16'(cnt);
        c4  = (cnt > 15) ? 4'hF : 4'(cnt);
        return {ed, ew, em, md, mw, wd, ww, hz, c16, c4};
    endfunction

    task automatic apply(input stim_t s);
        rst           = s.rst;
        forwarding_en = s.fwd;
        freeze        = s.frz;
        branch_taken  = s.br;
        id_valid      = s.v;
        id_src1       = s.s1;
        id_use_src1   = s.u1;
        id_src2       = s.s2;
        id_use_src2   = s.u2;
        id_dest       = s.d;
        id_wb_en      = s.wb;
        id_mem_read   = s.mr;
    endtask

    task automatic test_reset();
        stim_t st[$];
        logic [36:0] ev[$];
        stim_t s;
        exp_t  e;
        s = op(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
        s.rst = 1'b1;
        st.push_back(s); ev.push_back(mk(0,0,0, 0,0, 0,0, 0, 0));
        st.push_back(s); ev.push_back(mk(0,0,0, 0,0, 0,0, 0, 0));
        s.rst = 1'b0;
        st.push_back(s);      ev.push_back(mk(0,0,0, 0,0, 0,0, 0, 0));
        st.push_back(idle()); ev.push_back(mk(3,1,0, 0,0, 0,0, 0, 0));
        st.push_back(idle()); ev.push_back(mk(0,0,0, 3,1, 0,0, 0, 0));
        st.push_back(idle()); ev.push_back(mk(0,0,0, 0,0, 3,1, 0, 0));
        st.push_back(idle()); ev.push_back(mk(0,0,0, 0,0, 0,0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            @(negedge clk);
            apply(st[i]);
            sb.push_back('{$sformatf("reset[%0d]", i), ev[i]});
            #1;
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t st[$];
        logic [36:0] ev[$];
        stim_t ldr, sub;
        exp_t  e;
        ldr = op(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);
        sub = op(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);
        st.push_back(ldr);    ev.push_back(mk(0,0,0, 0,0, 0,0, 0, 0));
        st.push_back(sub);    ev.push_back(mk(5,1,1, 0,0, 0,0, 1, 0));
        st.push_back(sub);    ev.push_back(mk(0,0,0, 5,1, 0,0, 0, 1));
        st.push_back(idle()); ev.push_back(mk(6,1,0, 0,0, 5,1, 0, 1));
        st.push_back(idle()); ev.push_back(mk(0,0,0, 6,1, 0,0, 0, 1));
        st.push_back(idle()); ev.push_back(mk(0,0,0, 0,0, 6,1, 0, 1));
        st.push_back(idle()); ev.push_back(mk(0,0,0, 0,0, 0,0, 0, 1));
        for (int i = 0; i < st.size(); i++) begin
            @(negedge clk);
            apply(st[i]);
            sb.push_back('{$sformatf("load_use[%0d]", i), ev[i]});
            #1;
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
            end
        end
    endtask

    task automatic test_no_forwarding();
        stim_t st[$];
        logic [36:0] ev[$];
        stim_t add, c, cu, nop;
        exp_t  e;
        add = op(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0); add.fwd = 1'b0;
        c   = op(1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 4'd7, 1'b1, 1'b0); c.fwd   = 1'b0;
        cu  = op(1'b1, 4'd0, 1'b0, 4'd2, 1'b0, 4'd7, 1'b1, 1'b0); cu.fwd  = 1'b0;
        nop = idle(); nop.fwd = 1'b0;
        // Full two-cycle interlock.
        st.push_back(add); ev.push_back(mk(0,0,0, 0,0, 0,0, 0, 1));
        st.push_back(c);   ev.push_back(mk(2,1,0, 0,0, 0,0, 1, 1));
        st.push_back(c);   ev.push_back(mk(0,0,0, 2,1, 0,0, 1, 2));
        st.push_back(c);   ev.push_back(mk(0,0,0, 0,0, 2,1, 0, 3));
        st.push_back(nop); ev.push_back(mk(7,1,0, 0,0, 0,0, 0, 3));
        st.push_back(nop); ev.push_back(mk(0,0,0, 7,1, 0,0, 0, 3));
        st.push_back(nop); ev.push_back(mk(0,0,0, 0,0, 7,1, 0, 3));
        // Unused source never matches.
        st.push_back(add); ev.push_back(mk(0,0,0, 0,0, 0,0, 0, 3));
        st.push_back(cu);  ev.push_back(mk(2,1,0, 0,0, 0,0, 0, 3));
        st.push_back(nop); ev.push_back(mk(7,1,0, 2,1, 0,0, 0, 3));
        st.push_back(nop); ev.push_back(mk(0,0,0, 7,1, 2,1, 0, 3));
        st.push_back(nop); ev.push_back(mk(0,0,0, 0,0, 7,1, 0, 3));
        // Forwarding on: ALU result needs no stall; turning it off mid-flight
        // exposes the MEM match immediately.
        add.fwd = 1'b1;
        c.fwd   = 1'b1;
        st.push_back(add); ev.push_back(mk(0,0,0, 0,0, 0,0, 0, 3));
        st.push_back(c);   ev.push_back(mk(2,1,0, 0,0, 0,0, 0, 3));
        c.fwd = 1'b0;
        st.push_back(c);      ev.push_back(mk(7,1,0, 2,1, 0,0, 1, 3));
        st.push_back(idle()); ev.push_back(mk(0,0,0, 7,1, 2,1, 0, 4));
        st.push_back(idle()); ev.push_back(mk(0,0,0, 0,0, 7,1, 0, 4));
        st.push_back(idle()); ev.push_back(mk(0,0,0, 0,0, 0,0, 0, 4));
        for (int i = 0; i < st.size(); i++) begin
            @(negedge clk);
            apply(st[i]);
            sb.push_back('{$sformatf("no_fwd[%0d]", i), ev[i]});
            #1;
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
            end
        end
    endtask

    task automatic test_freeze();
        stim_t st[$];
        logic [36:0] ev[$];
        stim_t ldr, sub, subf;
        exp_t  e;
        ldr  = op(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);
        sub  = op(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);
        subf = sub; subf.frz = 1'b1;
        st.push_back(ldr);    ev.push_back(mk(0,0,0, 0,0, 0,0, 0, 4));
        st.push_back(subf);   ev.push_back(mk(5,1,1, 0,0, 0,0, 1, 4));
        st.push_back(subf);   ev.push_back(mk(5,1,1, 0,0, 0,0, 1, 4));
        st.push_back(subf);   ev.push_back(mk(5,1,1, 0,0, 0,0, 1, 4));
        st.push_back(sub);    ev.push_back(mk(5,1,1, 0,0, 0,0, 1, 4));
        st.push_back(sub);    ev.push_back(mk(0,0,0, 5,1, 0,0, 0, 5));
        st.push_back(idle()); ev.push_back(mk(6,1,0, 0,0, 5,1, 0, 5));
        st.push_back(idle()); ev.push_back(mk(0,0,0, 6,1, 0,0, 0, 5));
        st.push_back(idle()); ev.push_back(mk(0,0,0, 0,0, 6,1, 0, 5));
        st.push_back(idle()); ev.push_back(mk(0,0,0, 0,0, 0,0, 0, 5));
        for (int i = 0; i < st.size(); i++) begin
            @(negedge clk);
            apply(st[i]);
            sb.push_back('{$sformatf("freeze[%0d]", i), ev[i]});
            #1;
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
            end
        end
    endtask

    task automatic test_flush();
        stim_t st[$];
        logic [36:0] ev[$];
        stim_t ldr, subb;
        exp_t  e;
        ldr  = op(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);
        subb = op(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);
        subb.br = 1'b1;
        st.push_back(ldr);    ev.push_back(mk(0,0,0, 0,0, 0,0, 0, 5));
        st.push_back(subb);   ev.push_back(mk(5,1,1, 0,0, 0,0, 0, 5));
        st.push_back(idle()); ev.push_back(mk(0,0,0, 5,1, 0,0, 0, 5));
        st.push_back(idle()); ev.push_back(mk(0,0,0, 0,0, 5,1, 0, 5));
        st.push_back(idle()); ev.push_back(mk(0,0,0, 0,0, 0,0, 0, 5));
        for (int i = 0; i < st.size(); i++) begin
            @(negedge clk);
            apply(st[i]);
            sb.push_back('{$sformatf("flush[%0d]", i), ev[i]});
            #1;
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
            end
        end
    endtask

    // A self-dependent load (src1 = dest = R5) stalls every other cycle:
    // 40 cycles give 20 stalls, past the 4-bit limit of 15.
    task automatic test_saturation();
        stim_t st[$];
        logic [36:0] ev[$];
        stim_t s, ld;
        exp_t  e;
        s = idle(); s.rst = 1'b1;
        st.push_back(s); ev.push_back(mk(0,0,0, 0,0, 0,0, 0, 5));
        ld = op(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) begin
            st.push_back(ld);
            ev.push_back('x);
        end
        st.push_back(idle()); ev.push_back(mk(0,0,0, 5,1, 0,0, 0, 20));
        st.push_back(s);      ev.push_back(mk(0,0,0, 0,0, 5,1, 0, 20));
        st.push_back(idle()); ev.push_back(mk(0,0,0, 0,0, 0,0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            @(negedge clk);
            apply(st[i]);
            if (i >= 1 && i <= 40) continue;
            sb.push_back('{$sformatf("saturate[%0d]", i), ev[i]});
            #1;
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
            end
        end
    endtask

    initial begin
        apply(idle());
        rst = 1'b1;
        test_reset();
        test_load_use();
        test_no_forwarding();
        test_freeze();
        test_flush();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
